// File: rtl/circular_arc_step_counter.sv
// Registered step count (Manhattan arc length) for a circular move, exact or quadrant-granular.
// Optional build macro CIRC_STEPS_CLAMP_EN saturates the registered result to 8r.
module circular_arc_step_counter #(
    parameter  int NUM_BITS  = 8,
    localparam int STEP_BITS = NUM_BITS + 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_cw,
    input  logic [NUM_BITS-1:0]  start_x,
    input  logic [NUM_BITS-1:0]  start_y,
    input  logic [NUM_BITS-1:0]  end_x,
    input  logic [NUM_BITS-1:0]  end_y,
    input  logic [NUM_BITS-1:0]  r,
    input  logic                 precise_crossing_axes,
    input  logic                 is_full_circle,
    output logic [STEP_BITS-1:0] num_steps
);

    // Two bits of headroom over the result keep off-circle perimeter sums from wrapping.
    localparam int W = STEP_BITS + 2;
    typedef logic signed [W-1:0] wide_t;

    function automatic logic [1:0] quadrant(input logic signed [NUM_BITS-1:0] x,
                                            input logic signed [NUM_BITS-1:0] y);
        if (x > 0 && y >= 0)       return 2'd0;
        else if (x <= 0 && y > 0)  return 2'd1;
        else if (x < 0 && y <= 0)  return 2'd2;
        else                       return 2'd3;
    endfunction

    function automatic wide_t perim_pos(input logic signed [NUM_BITS-1:0] x,
                                        input logic signed [NUM_BITS-1:0] y,
                                        input wide_t r1, input wide_t r2,
                                        input wide_t r4, input wide_t r6);
        wide_t xw, yw, p;
        xw = wide_t'(x);
        yw = wide_t'(y);
        case (quadrant(x, y))
            2'd0:    p = (r1 - xw) + yw;
            2'd1:    p = r2 - xw + (r1 - yw);
            2'd2:    p = r4 + (xw + r1) - yw;
            default: p = r6 + xw + (yw + r1);
        endcase
        if (p < 0) p = '0;
        return p;
    endfunction

    wide_t                r1, r2, r4, r6, r8;
    wide_t                p_start, p_end, diff, coarse, raw;
    logic [1:0]           q_start, q_end, q_diff;
    logic [2:0]           k;
    logic                 behind, same_point;
    logic [STEP_BITS-1:0] next_steps;

    // NOTE: combinational logic uses blocking assignments and assigns every output up front,
    // so values chain in order within the block and no latch can be inferred.
    always_comb begin
        r1 = wide_t'(r);
        r2 = r1 + r1;
        r4 = r2 + r2;
        r6 = r4 + r2;
        r8 = r4 + r4;

        p_start = perim_pos(start_x, start_y, r1, r2, r4, r6);
        p_end   = perim_pos(end_x, end_y, r1, r2, r4, r6);

        // Modulo 8r by a single conditional correction either way; no divider.
        diff = is_cw ? (p_start - p_end) : (p_end - p_start);
        if (diff < 0)   diff = diff + r8;
        if (diff >= r8) diff = diff - r8;

        q_start    = quadrant(start_x, start_y);
        q_end      = quadrant(end_x, end_y);
        q_diff     = is_cw ? (q_start - q_end) : (q_end - q_start);
        behind     = is_cw ? (p_end > p_start) : (p_end < p_start);
        same_point = (start_x == end_x) && (start_y == end_y);

        k = {1'b0, q_diff} + 3'd1;
        if (is_full_circle || (q_start == q_end && behind)) k = 3'd4;

        case (k)
            3'd1:    coarse = r2;
            3'd2:    coarse = r4;
            3'd3:    coarse = r6;
            default: coarse = r8;
        endcase

        if (precise_crossing_axes)
            raw = is_full_circle ? r8 : diff;
        else
            raw = (same_point && !is_full_circle) ? wide_t'(0) : coarse;

        if (r == '0) raw = '0;
`ifdef CIRC_STEPS_CLAMP_EN
        if (raw > r8) raw = r8;
`else
`endif
        next_steps = raw[STEP_BITS-1:0];
    end

    // NOTE: registers use non-blocking assignments; reset here is synchronous and wins over the update.
    always_ff @(posedge clk) begin
        if (reset) num_steps <= '0;
        else       num_steps <= next_steps;
    end

endmodule

// File: tb/tb_circular_arc_step_counter.sv
// Directed self-checking bench for circular_arc_step_counter (NUM_BITS=8, default build).
module tb_circular_arc_step_counter;

    logic              clk = 1'b0;
    logic              reset;
    logic              is_cw;
    logic signed [7:0] start_x, start_y, end_x, end_y;
    logic [7:0]        r;
    logic              precise_crossing_axes;
    logic              is_full_circle;
    logic [10:0]       num_steps;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic   cw;
        int     sx, sy, ex, ey, rad;
        logic   prec, full;
        int     exp;
    } vec_t;

    circular_arc_step_counter #(.NUM_BITS(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .is_cw                (is_cw),
        .start_x              (start_x),
        .start_y              (start_y),
        .end_x                (end_x),
        .end_y                (end_y),
        .r                    (r),
        .precise_crossing_axes(precise_crossing_axes),
        .is_full_circle       (is_full_circle),
        .num_steps            (num_steps)
    );

    always #5 clk = ~clk;

    task automatic drive(input vec_t v);
        is_cw                 = v.cw;
        start_x               = 8'(v.sx);
        start_y               = 8'(v.sy);
        end_x                 = 8'(v.ex);
        end_y                 = 8'(v.ey);
        r                     = 8'(v.rad);
        precise_crossing_axes = v.prec;
        is_full_circle        = v.full;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive('{1'b1, 2, 0, 0, 2, 2, 1'b1, 1'b0, 12});
        reset = 1'b1;
        step();
        step();
        tests_run++;
        if (num_steps !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected 0", num_steps);
        end
    endtask

    task automatic run_table(input string tag, input vec_t tbl[]);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            step();
            tests_run++;
            if (num_steps !== 11'(tbl[i].exp)) begin
                tests_failed++;
                $display("FAIL %s[%0d]: got %0d expected %0d", tag, i, num_steps, tbl[i].exp);
            end
        end
    endtask

    task automatic test_precise();
        vec_t tbl[] = '{
            '{1'b0,  2,  0,  0,  2, 2, 1'b1, 1'b0,  4},
            '{1'b0,  0,  2,  0, -2, 2, 1'b1, 1'b0,  8},
            '{1'b0,  0,  2,  0,  2, 2, 1'b1, 1'b1, 16},
            '{1'b1,  2,  0,  0,  2, 2, 1'b1, 1'b0, 12},
            '{1'b1,  0,  2,  0, -2, 2, 1'b1, 1'b0,  8},
            '{1'b1,  2,  0,  2,  0, 2, 1'b1, 1'b1, 16},
            '{1'b0,  2,  0,  2,  0, 2, 1'b1, 1'b0,  0},
            '{1'b0,  0, -2,  2,  0, 2, 1'b1, 1'b0,  4}
        };
        run_table("precise", tbl);
    endtask

    task automatic test_coarse();
        vec_t tbl[] = '{
            '{1'b0,  2,  0,  0,  2, 2, 1'b0, 1'b0,  8},
            '{1'b0,  1,  1,  2,  0, 2, 1'b0, 1'b0, 16},
            '{1'b1,  2,  0,  0,  2, 2, 1'b0, 1'b0, 16},
            '{1'b1,  0,  2,  2,  0, 2, 1'b0, 1'b0,  8},
            '{1'b0,  2,  0,  2,  0, 2, 1'b0, 1'b0,  0},
            '{1'b0,  2,  0,  2,  0, 2, 1'b0, 1'b1, 16},
            '{1'b0,  2,  0,  1,  1, 2, 1'b0, 1'b0,  4}
        };
        run_table("coarse", tbl);
    endtask

    task automatic test_boundary();
        vec_t tbl[] = '{
            '{1'b0,  127, 0,  127, 0, 127, 1'b1, 1'b1, 1016},
            '{1'b1,  127, 0,  127, 0, 127, 1'b0, 1'b1, 1016},
            '{1'b0,  127, 0, -127, 0, 127, 1'b1, 1'b0,  508},
            '{1'b0,    0, 0,    0, 0,   0, 1'b1, 1'b1,    0},
            '{1'b0,    2, 0,    0, 2,   0, 1'b0, 1'b0,    0}
        };
        run_table("boundary", tbl);
    endtask

    task automatic test_back_to_back();
        drive('{1'b1, 2, 0, 0, 2, 2, 1'b1, 1'b0, 12});
        step();
        tests_run++;
        if (num_steps !== 11'd12) begin
            tests_failed++;
            $display("FAIL b2b_first: got %0d expected 12", num_steps);
        end
        reset = 1'b1;
        step();
        tests_run++;
        if (num_steps !== 11'd0) begin
            tests_failed++;
            $display("FAIL b2b_reset: got %0d expected 0", num_steps);
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (num_steps !== 11'd12) begin
            tests_failed++;
            $display("FAIL b2b_release: got %0d expected 12", num_steps);
        end
        // New inputs must not show until the next edge.
        drive('{1'b0, 2, 0, 0, 2, 2, 1'b1, 1'b0, 4});
        #2;
        tests_run++;
        if (num_steps !== 11'd12) begin
            tests_failed++;
            $display("FAIL b2b_latency: got %0d expected 12", num_steps);
        end
        step();
        tests_run++;
        if (num_steps !== 11'd4) begin
            tests_failed++;
            $display("FAIL b2b_update: got %0d expected 4", num_steps);
        end
    endtask

    initial begin
        test_reset();
        reset = 1'b0;
        test_precise();
        test_coarse();
        test_boundary();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/circular_arc_step_counter.md
Name: circular_arc_step_counter

Overview:
- Computes the number of unit motor steps needed to trace a circular arc for the circular-move op handler.
- The arc is given by its start and end points relative to the circle centre, its radius, its direction and a full-circle flag.
- A step is one unit move in X or Y, so the step count is the Manhattan length of the arc; one quadrant costs 2r steps.
- Sits between the op decoder and the circular stepping engine; output is registered.

Parameters:
- NUM_BITS, 8, width of coordinates and radius. Output width STEP_BITS = NUM_BITS+3 (derived, not overridable).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- is_cw  in  1  1 = clockwise arc, 0 = counter-clockwise
- start_x, start_y  in  NUM_BITS  arc start relative to centre, signed two's complement
- end_x, end_y  in  NUM_BITS  arc end relative to centre, signed two's complement
- r  in  NUM_BITS  radius, unsigned, legal range 0..2^(NUM_BITS-1)-1
- precise_crossing_axes  in  1  1 = exact count, 0 = quadrant-granular upper bound
- is_full_circle  in  1  1 = full revolution, start and end points ignored
- num_steps  out  STEP_BITS  required step count, unsigned

Behaviour:
- Single clock domain. Inputs are sampled every rising edge; num_steps is registered with 1-cycle latency. There is no handshake; the result follows the inputs continuously.
- reset=1 at a rising edge forces num_steps to 0. Reset has priority over computation.
- Quadrant index of a point (axis points belong to one quadrant only):
  - Q0: x>0, y>=0
  - Q1: x<=0, y>0
  - Q2: x<0, y<=0
  - Q3: x>=0, y<0
- Perimeter position p in [0, 8r), measured CCW from (r,0):
  - Q0: (r-x)+y
  - Q1: 2r+(-x)+(r-y)
  - Q2: 4r+(x+r)+(-y)
  - Q3: 6r+x+(y+r)
  - Compute p in at least STEP_BITS+1 signed bits; clamp negative intermediates to 0.
- Precise mode (precise_crossing_axes=1):
  - d = (p_end - p_start) mod 8r when CCW; d = (p_start - p_end) mod 8r when CW.
  - is_full_circle=1 gives num_steps = 8r.
  - d=0 with is_full_circle=0 gives 0.
- Coarse mode (precise_crossing_axes=0):
  - k = ((q_end - q_start) mod 4) + 1 when CCW; k = ((q_start - q_end) mod 4) + 1 when CW.
  - If q_start=q_end and the end lies behind the start in the travel direction, k=4.
  - is_full_circle=1 gives k=4.
  - Start point equal to end point with is_full_circle=0 gives 0.
  - Otherwise num_steps = 2r·k.
  - Coarse result is always >= the precise result.
- r=0 gives num_steps 0 in every mode.
- Points that are not exactly on the circle still produce the formula result; no error flag is raised.
- The modulo-8r reduction is done by conditional add/subtract of 8r. No divider is allowed.

Optional Feature:
- Macro CIRC_STEPS_CLAMP_EN.
- When defined, the registered result is saturated to 8r, which covers off-circle points whose p exceeds the perimeter.
- When undefined, the raw result is registered; it is truncated to STEP_BITS.

Test Plan:
- NUM_BITS=8, r=2, CCW, precise, (2,0)->(0,2) -> num_steps=4 one cycle later.
- r=2, CCW, precise, (0,2)->(0,-2) -> 8; same with is_full_circle=1, (0,2)->(0,2) -> 16.
- r=2, CW, precise, (2,0)->(0,2) -> 12; (0,2)->(0,-2) -> 8; full circle -> 16.
- r=2, CCW, coarse, (2,0)->(0,2) -> 8 (k=2); CW, coarse, (2,0)->(2,-... same quadrant behind) e.g. (1,1)->(2,0)... CCW coarse (2,0)->(1,1) hmm: CCW coarse (1,1)->(2,0) -> 16.
- Assert reset while inputs give 12 -> num_steps=0 the next cycle; release reset -> 12 one cycle later.
- r=127, full circle, precise -> 1016, which fits in 11 bits; r=0 with any points -> 0.
